// File: rtl/addsub_serial_hex.sv
// addsub_serial_hex: bit-serial add / subtract / absolute-difference unit.
// B is captured from op_a on a load edge; A is op_a sampled on the start edge.
// The result is formed LSB-first, one full-adder step per clock, and three
// banks of active-low 7-segment digits show live A, stored B and the last result.
// Build option: define ADDSUB_SATURATE_EN to clamp add overflow to all-ones
// and subtract underflow (A-B, B-A) to zero instead of wrapping.
//
// state  | meaning
// S_IDLE | waiting for a start edge; load edges update B
// S_RUN  | one serial add/subtract step per cycle, WIDTH steps
// S_NEG  | |A-B| with A<B: serial 0 - x of the partial result, WIDTH steps
// S_DONE | result/flag just updated; done pulses for this single cycle
module addsub_serial_hex #(
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       op_a,
  input  logic                   load,
  input  logic                   start,
  input  logic [1:0]             mode,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic                   flag,
  output logic [7*WIDTH/4-1:0]   hex_a,
  output logic [7*WIDTH/4-1:0]   hex_b,
  output logic [7*WIDTH/4-1:0]   hex_r
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             load_q, start_q;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;

  logic             load_edge, start_edge;
  logic             y_bit, sum_bit, carry_out, borrow;
  logic             neg_bit, neg_carry;
  logic [WIDTH-1:0] sum_full, neg_full;

  assign load_edge  = load & ~load_q;
  assign start_edge = start & ~start_q;

  // Subtraction adds the inverted subtrahend with carry-in 1.
  assign y_bit     = y_q[0] ^ sub_q;
  assign sum_bit   = x_q[0] ^ y_bit ^ carry_q;
  assign carry_out = (x_q[0] & y_bit) | (x_q[0] & carry_q) | (y_bit & carry_q);
  assign borrow    = sub_q & ~carry_out;
  assign sum_full  = {sum_bit, acc_q[WIDTH-1:1]};

  // Negation 0 - x = ~x + 1, applied bit by bit to the rotating accumulator.
  assign neg_bit   = ~acc_q[0] ^ carry_q;
  assign neg_carry = ~acc_q[0] & carry_q;
  assign neg_full  = {neg_bit, acc_q[WIDTH-1:1]};

  assign busy   = (state_q == S_RUN) || (state_q == S_NEG);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flag   = flag_q;

  // State, datapath and edge-detect registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      load_q   <= 1'b0;
      start_q  <= 1'b0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      mode_q   <= 2'b00;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load;
      start_q  <= start;
      b_q      <= b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state and datapath updates for the serial sequencer.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;

    // B is frozen while an operation is in flight.
    if (load_edge && !busy) b_d = op_a;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          // B-A swaps the operand roles so the datapath always computes x - y.
          x_d     = (mode == 2'b11) ? b_q : op_a;
          y_d     = (mode == 2'b11) ? op_a : b_q;
          sub_d   = (mode != 2'b00);
          carry_d = (mode != 2'b00);
          mode_d  = mode;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x_d     = x_q >> 1;
        y_d     = y_q >> 1;
        acc_d   = sum_full;
        carry_d = carry_out;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          case (mode_q)
            2'b00: begin
              flag_d   = carry_out;
              result_d = (SAT && carry_out) ? '1 : sum_full;
            end
            2'b10: begin
              if (borrow) begin
                carry_d = 1'b1;
                cnt_d   = CW'(WIDTH - 1);
                state_d = S_NEG;
              end else begin
                flag_d   = |sum_full;
                result_d = sum_full;
              end
            end
            default: begin
              flag_d   = borrow;
              result_d = (SAT && borrow) ? '0 : sum_full;
            end
          endcase
        end
      end
      S_NEG: begin
        acc_d   = neg_full;
        carry_d = neg_carry;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = neg_full;
          flag_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  for (genvar k = 0; k < DIGITS; k++) begin : g_hex
    assign hex_a[7*k+6:7*k] = seg7(op_a[4*k+3:4*k]);
    assign hex_b[7*k+6:7*k] = seg7(b_q[4*k+3:4*k]);
    assign hex_r[7*k+6:7*k] = seg7(result_q[4*k+3:4*k]);
  end

endmodule

// File: tb/tb_addsub_serial_hex.sv
// Randomized self-checking bench for addsub_serial_hex (WIDTH=8 main instance,
// plus a WIDTH=16 instance for the wide-operand case).
module tb_addsub_serial_hex;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  op_a;
  logic        load, start;
  logic [1:0]  mode;
  logic        busy, done, flag;
  logic [7:0]  result;
  logic [13:0] hex_a, hex_b, hex_r;

  logic [15:0] op_a16;
  logic        load16, start16;
  logic [1:0]  mode16;
  logic        busy16, done16, flag16;
  logic [15:0] result16;
  logic [27:0] hex_a16, hex_b16, hex_r16;

  int errs   = 0;
  int checks = 0;
  logic [15:0] b_model;

  always #5 CLK = ~CLK;

  addsub_serial_hex #(.WIDTH(8)) u_dut (
    .CLK(CLK), .reset(reset), .op_a(op_a), .load(load), .start(start), .mode(mode),
    .busy(busy), .done(done), .result(result), .flag(flag),
    .hex_a(hex_a), .hex_b(hex_b), .hex_r(hex_r)
  );

  addsub_serial_hex #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .reset(reset), .op_a(op_a16), .load(load16), .start(start16), .mode(mode16),
    .busy(busy16), .done(done16), .result(result16), .flag(flag16),
    .hex_a(hex_a16), .hex_b(hex_b16), .hex_r(hex_r16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b0000001;  4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;  4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;  4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;  4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;  4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;  default: glyph = 7'b0111000;
    endcase
  endfunction

  function automatic logic [63:0] hex_exp(input logic [15:0] v, input int digs);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < digs; k++) r[7*k +: 7] = glyph(v[4*k +: 4]);
    return r;
  endfunction

  // Arithmetic reference: plain integer maths on the operand values.
  task automatic ref_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                        input int w, output logic [15:0] r, output logic f, output int lat);
    longint av, bv, mask, s;
    av = longint'(a); bv = longint'(b);
    mask = (longint'(1) << w) - 1;
    lat = w + 1;
    case (m)
      2'b00: begin s = av + bv; f = (s > mask); s = s & mask; end
      2'b01: begin f = (av < bv); s = (av - bv) & mask; end
      2'b11: begin f = (bv < av); s = (bv - av) & mask; end
      default: begin
        f = (av > bv);
        s = (av >= bv) ? av - bv : bv - av;
        if (av < bv) lat = 2 * w + 1;
      end
    endcase
`ifdef ADDSUB_SATURATE_EN
    if (m == 2'b00 && f) s = mask;
    if ((m == 2'b01 || m == 2'b11) && f) s = 0;
`endif
    r = 16'(s);
  endtask

  task automatic load_b(input logic [7:0] v);
    @(negedge CLK);
    op_a = v; load = 1'b1;
    @(negedge CLK);
    load = 1'b0;
    b_model = {8'h00, v};
  endtask

  // One operation: hold = cycle at which start drops; disturb pokes start/load
  // while busy; ld raises load together with start.
  task automatic do_op(input logic [7:0] a, input logic [1:0] m, input int hold,
                       input bit disturb, input bit ld);
    logic [15:0] er;
    logic        ef;
    int          elat, first, ndone;
    ref_op({8'h00, a}, b_model, m, 8, er, ef, elat);
    @(negedge CLK);
    op_a = a; mode = m; start = 1'b1;
    if (ld) begin load = 1'b1; b_model = {8'h00, a}; end
    first = 0; ndone = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge CLK);
      if (n == 1) begin chk("busy_after_start", busy, 1); load = 1'b0; end
      if (n == hold) start = 1'b0;
      if (disturb) begin
        if (n == 3) start = 1'b0;
        if (n == 4) start = 1'b1;
        if (n == 5) begin op_a = 8'($urandom); load = 1'b1; end
        if (n == 6) load = 1'b0;
        if (n == 7) start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n;
          chk("result", result, er[7:0]);
          chk("flag", flag, ef);
          chk("busy_at_done", busy, 0);
          chk("hex_r", hex_r, hex_exp(er, 2));
        end
      end
    end
    start = 1'b0;
    chk("latency", first, elat);
    chk("done_pulses", ndone, 1);
    chk("hex_b", hex_b, hex_exp(b_model, 2));
  endtask

  initial begin
    int first, ndone;
    reset = 1'b1; op_a = '0; load = 0; start = 0; mode = 0;
    op_a16 = '0; load16 = 0; start16 = 0; mode16 = 0;
    b_model = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flag", flag, 0);
    chk("rst_hex_b", hex_b, 14'b0000001_0000001);
    chk("rst_hex_r", hex_r, 14'b0000001_0000001);
    reset = 1'b0;

    // Directed cases.
    load_b(8'h35);
    do_op(8'h5A, 2'b00, 1, 0, 0);
    chk("hex_r_8F", hex_r, 14'b0000000_0111000);
    load_b(8'hF0);
    do_op(8'h20, 2'b00, 1, 0, 0);
    load_b(8'h35);
    do_op(8'h10, 2'b10, 1, 0, 0);
    do_op(8'h35, 2'b10, 1, 0, 0);
    do_op(8'h10, 2'b01, 1, 0, 0);
    do_op(8'h10, 2'b11, 1, 0, 0);
    do_op(8'h44, 2'b00, 30, 0, 0);
    do_op(8'h99, 2'b10, 1, 1, 0);
    do_op(8'h01, 2'b10, 1, 1, 0);
    do_op(8'h77, 2'b01, 1, 0, 1);
    @(negedge CLK);
    op_a = 8'h8F;
    #1 chk("hex_a", hex_a, hex_exp(16'h008F, 2));

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(2) == 0) load_b(8'($urandom));
      do_op(8'($urandom), 2'($urandom), ($urandom_range(3) == 0) ? 25 : 1,
            $urandom_range(3) == 0, $urandom_range(4) == 0);
    end

    // Reset in the middle of a run.
    @(negedge CLK);
    op_a = 8'hC3; mode = 2'b00; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("busy_mid_run", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_hex_b", hex_b, hex_exp(16'h0000, 2));
    b_model = '0;
    @(negedge CLK);
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // Wide instance.
    @(negedge CLK);
    op_a16 = 16'h1235; load16 = 1'b1;
    @(negedge CLK);
    load16 = 1'b0; op_a16 = 16'h005A; mode16 = 2'b00; start16 = 1'b1;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (n == 1) start16 = 1'b0;
      if (done16 && first == 0) begin
        first = n;
        chk("w16_result", result16, 16'h128F);
        chk("w16_flag", flag16, 0);
        chk("w16_hex_r", hex_r16, hex_exp(16'h128F, 4));
      end
    end
    chk("w16_latency", first, 17);
    chk("w16_hex_b", hex_b16, hex_exp(16'h1235, 4));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
